// File: rtl/codma_pkg.sv
// Shared types and helpers for the CODMA read/write bus-master controller.
package codma_pkg;

    localparam int MAX_BURST_DEF     = 8;
    localparam int GRANT_TIMEOUT_DEF = 16;

    // Channel state encoding is visible on the rd_state_o / wr_state_o ports.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASK     = 2'd1,
        GRANTED = 2'd2
    } chan_state_t;

    // Bus ownership: which channel currently drives the master port.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_RD   = 2'd1,
        OWN_WR   = 2'd2
    } owner_t;

    // Length / beat-count field width able to hold 0..max_burst.
    function automatic int len_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/codma_chan_fsm.sv
// One CODMA channel: request capture, ASK/GRANTED sequencing, beat counting,
// grant timeout and done/err pulse generation.
module codma_chan_fsm
    import codma_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int MAX_BURST     = MAX_BURST_DEF,
    parameter int LEN_W         = len_width(MAX_BURST),
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              own_i,
    input  logic              grant_i,
    input  logic              beat_i,
    input  logic              error_i,
    output chan_state_t       state_o,
    output logic [LEN_W-1:0]  beat_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              done_o,
    output logic              err_o,
    output logic              fin_o,
    output logic              abort_o
);

    localparam int TMO_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    chan_state_t       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              done_q;
    logic              err_q;

    logic len_ok;
    logic tmo_hit;
    logic bus_abort;
    logic last_beat;

    // Decode the events that end a burst or raise an error this cycle.
    always_comb begin
        len_ok    = (len_i != '0) && (len_i <= LEN_W'(MAX_BURST));
        tmo_hit   = 1'b0;
        if (GRANT_TIMEOUT != 0) begin
            tmo_hit = (state_q == ASK) && own_i && !grant_i &&
                      (tmo_cnt_q == TMO_W'(GRANT_TIMEOUT - 1));
        end
        // Error wins over a simultaneous final beat.
        bus_abort = (state_q == GRANTED) && own_i && error_i;
        last_beat = (state_q == GRANTED) && own_i && !error_i && beat_i &&
                    (beat_q == len_q - LEN_W'(1));
        fin_o     = tmo_hit || bus_abort || last_beat;
        abort_o   = tmo_hit || bus_abort || ((state_q == IDLE) && req_i && !len_ok);
    end

    // Channel state machine with registered done/err pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            tmo_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (len_ok) begin
                            addr_q    <= addr_i;
                            len_q     <= len_i;
                            beat_q    <= '0;
                            tmo_cnt_q <= '0;
                            state_q   <= ASK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ASK: begin
                    if (own_i && grant_i) begin
                        state_q <= GRANTED;
                        beat_q  <= '0;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (own_i && (GRANT_TIMEOUT != 0)) begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                GRANTED: begin
                    if (bus_abort) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (own_i && beat_i) begin
                        beat_q <= beat_q + LEN_W'(1);
                        if (last_beat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign beat_o  = beat_q;
    assign addr_o  = addr_q;
    assign len_o   = len_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: rtl/codma_rdwr_channel_fsm.sv
// CODMA read/write bus-master controller: two channel FSMs sharing one bus
// master port through a fair (last-owner-loses) arbiter.
module codma_rdwr_channel_fsm
    import codma_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int MAX_BURST     = MAX_BURST_DEF,
    parameter int LEN_W         = len_width(MAX_BURST),
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LEN_W-1:0]  wr_len_i,
    output logic              bus_req_o,
    output logic              bus_write_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [LEN_W-1:0]  bus_size_o,
    input  logic              bus_grant_i,
    input  logic              bus_beat_i,
    input  logic              bus_error_i,
    output logic [1:0]        rd_state_o,
    output logic [1:0]        wr_state_o,
    output logic [LEN_W-1:0]  rd_beat_o,
    output logic [LEN_W-1:0]  wr_beat_o,
    output logic              rd_done_o,
    output logic              wr_done_o,
    output logic              rd_err_o,
    output logic              wr_err_o,
    output logic              err_sticky_o
);

    owner_t owner_q;
    owner_t last_owner_q;
    logic   sticky_q;

    chan_state_t       rd_state, wr_state;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [LEN_W-1:0]  rd_len, wr_len;
    logic              rd_fin, wr_fin;
    logic              rd_abort, wr_abort;
    logic              rd_own, wr_own;

    assign rd_own = (owner_q == OWN_RD);
    assign wr_own = (owner_q == OWN_WR);

    codma_chan_fsm #(
        .ADDR_W        (ADDR_W),
        .MAX_BURST     (MAX_BURST),
        .LEN_W         (LEN_W),
        .GRANT_TIMEOUT (GRANT_TIMEOUT)
    ) u_rd (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .req_i   (rd_req_i),
        .addr_i  (rd_addr_i),
        .len_i   (rd_len_i),
        .own_i   (rd_own),
        .grant_i (bus_grant_i),
        .beat_i  (bus_beat_i),
        .error_i (bus_error_i),
        .state_o (rd_state),
        .beat_o  (rd_beat_o),
        .addr_o  (rd_addr),
        .len_o   (rd_len),
        .done_o  (rd_done_o),
        .err_o   (rd_err_o),
        .fin_o   (rd_fin),
        .abort_o (rd_abort)
    );

    codma_chan_fsm #(
        .ADDR_W        (ADDR_W),
        .MAX_BURST     (MAX_BURST),
        .LEN_W         (LEN_W),
        .GRANT_TIMEOUT (GRANT_TIMEOUT)
    ) u_wr (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .req_i   (wr_req_i),
        .addr_i  (wr_addr_i),
        .len_i   (wr_len_i),
        .own_i   (wr_own),
        .grant_i (bus_grant_i),
        .beat_i  (bus_beat_i),
        .error_i (bus_error_i),
        .state_o (wr_state),
        .beat_o  (wr_beat_o),
        .addr_o  (wr_addr),
        .len_o   (wr_len),
        .done_o  (wr_done_o),
        .err_o   (wr_err_o),
        .fin_o   (wr_fin),
        .abort_o (wr_abort)
    );

    // Arbiter: pick an owner only when the bus is free; release when the owner returns to IDLE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q      <= OWN_NONE;
            last_owner_q <= OWN_WR;
            sticky_q     <= 1'b0;
        end else begin
            sticky_q <= sticky_q || rd_abort || wr_abort;
            case (owner_q)
                OWN_NONE: begin
                    if ((rd_state == ASK) && (wr_state == ASK)) begin
                        owner_q <= (last_owner_q == OWN_RD) ? OWN_WR : OWN_RD;
                    end else if (rd_state == ASK) begin
                        owner_q <= OWN_RD;
                    end else if (wr_state == ASK) begin
                        owner_q <= OWN_WR;
                    end
                end
                OWN_RD: begin
                    if (rd_fin) begin
                        owner_q      <= OWN_NONE;
                        last_owner_q <= OWN_RD;
                    end
                end
                OWN_WR: begin
                    if (wr_fin) begin
                        owner_q      <= OWN_NONE;
                        last_owner_q <= OWN_WR;
                    end
                end
                default: owner_q <= OWN_NONE;
            endcase
        end
    end

    // Bus port reflects only the owner's captured request; all-zero when free.
    always_comb begin
        bus_req_o   = 1'b0;
        bus_write_o = 1'b0;
        bus_addr_o  = '0;
        bus_size_o  = '0;
        case (owner_q)
            OWN_RD: begin
                bus_req_o  = 1'b1;
                bus_addr_o = rd_addr;
                bus_size_o = rd_len;
            end
            OWN_WR: begin
                bus_req_o   = 1'b1;
                bus_write_o = 1'b1;
                bus_addr_o  = wr_addr;
                bus_size_o  = wr_len;
            end
            default: ;
        endcase
    end

    assign rd_state_o   = rd_state;
    assign wr_state_o   = wr_state;
    assign err_sticky_o = sticky_q;

endmodule
